// File: rtl/branch_target_buffer_pkg.sv
// Shared constants and PC field helpers for the branch target buffer.
// The index/tag helpers are also meant for the direction predictor's hash,
// so both structures slice the PC the same way.
package branch_target_buffer_pkg;

    localparam int BTB_DEPTH   = 6;                 // log2 of entry count
    localparam int BTB_ENTRIES = 1 << BTB_DEPTH;    // 64 entries
    localparam int TAG_W       = 32 - 2 - BTB_DEPTH; // all remaining PC bits

    typedef logic [BTB_DEPTH-1:0] btbIdx_t;
    typedef logic [TAG_W-1:0]     btbTag_t;

    // Index field: word-aligned PC bits just above the byte offset.
    function automatic btbIdx_t btbIndex(input logic [31:0] pc);
        return pc[BTB_DEPTH+1:2];
    endfunction

    // Tag field: every PC bit above the index, so a hit never aliases.
    function automatic btbTag_t btbTag(input logic [31:0] pc);
        return pc[31:BTB_DEPTH+2];
    endfunction

endpackage

// File: rtl/branch_target_buffer_btb_array.sv
// Storage for the branch target buffer: a valid vector with a synchronous
// clear, plus tag and target arrays. One combinational read port and one
// synchronous write port. Reads always return the pre-edge contents.
module btb_array
    import branch_target_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  btbIdx_t     rdIdx,
    output logic        rdValid,
    output btbTag_t     rdTag,
    output logic [31:0] rdTarget,
    input  logic        wrEn,
    input  btbIdx_t     wrIdx,
    input  btbTag_t     wrTag,
    input  logic [31:0] wrTarget
);

    logic [BTB_ENTRIES-1:0] validVec;
    btbTag_t                tagMem    [BTB_ENTRIES];
    logic [31:0]            targetMem [BTB_ENTRIES];

    // Valid bits: reset drops every entry at once and beats a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            validVec <= '0;
        end else if (wrEn) begin
            validVec[wrIdx] <= 1'b1;
        end
    end

    // Tag/target payload: no reset needed, the valid bit guards it.
    always_ff @(posedge clk) begin
        if (wrEn && !rst) begin
            tagMem[wrIdx]    <= wrTag;
            targetMem[wrIdx] <= wrTarget;
        end
    end

    assign rdValid  = validVec[rdIdx];
    assign rdTag    = tagMem[rdIdx];
    assign rdTarget = targetMem[rdIdx];

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the fetch stage. Looks up pcF
// combinationally, registers the result into decode alongside the direction
// prediction, and is trained by taken branches resolved in M.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        branchM,
    input  logic        actual_takeM,
    input  logic [31:0] pcM,
    input  logic [31:0] branch_targetM,
    output logic        btb_hitF,
    output logic [31:0] btb_targetF,
    output logic        btb_hitD,
    output logic [31:0] btb_targetD
);

    logic        rdValid;
    btbTag_t     rdTag;
    logic [31:0] rdTarget;
    logic        wrEn;

    // Byte-offset bits never take part in indexing or tagging.
    logic [3:0]  unusedPcBits;
    assign unusedPcBits = {pcF[1:0], pcM[1:0]};

    // Only taken branches allocate; not-taken ones leave the entry alone.
    assign wrEn = branchM & actual_takeM;

    btb_array u_array (
        .clk      (clk),
        .rst      (rst),
        .rdIdx    (btbIndex(pcF)),
        .rdValid  (rdValid),
        .rdTag    (rdTag),
        .rdTarget (rdTarget),
        .wrEn     (wrEn),
        .wrIdx    (btbIndex(pcM)),
        .wrTag    (btbTag(pcM)),
        .wrTarget (branch_targetM)
    );

    // F-stage hit: valid entry with a full tag match; target forced to 0 on miss.
    always_comb begin
        btb_hitF    = rdValid && (rdTag == btbTag(pcF));
        btb_targetF = btb_hitF ? rdTarget : 32'h0;
    end

    // F->D register: reset/flush clear, stall holds, otherwise capture.
    always_ff @(posedge clk) begin
        if (rst || flushD) begin
            btb_hitD    <= 1'b0;
            btb_targetD <= 32'h0;
        end else if (!stallD) begin
            btb_hitD    <= btb_hitF;
            btb_targetD <= btb_targetF;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: a behavioural model predicts
// F and D outputs, expectations go through queues, directed checks pin the
// key scenarios to constant values.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        stallD;
    logic        flushD;
    logic        branchM;
    logic        actual_takeM;
    logic [31:0] pcM;
    logic [31:0] branch_targetM;
    logic        btb_hitF;
    logic [31:0] btb_targetF;
    logic        btb_hitD;
    logic [31:0] btb_targetD;

    branch_target_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .pcF            (pcF),
        .stallD         (stallD),
        .flushD         (flushD),
        .branchM        (branchM),
        .actual_takeM   (actual_takeM),
        .pcM            (pcM),
        .branch_targetM (branch_targetM),
        .btb_hitF       (btb_hitF),
        .btb_targetF    (btb_targetF),
        .btb_hitD       (btb_hitD),
        .btb_targetD    (btb_targetD)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    // scoreboard queues: {hit, target}
    logic [32:0] exp_q[$];
    logic [32:0] expD_q[$];

    // reference model state
    logic        mValid [64];
    logic [23:0] mTag   [64];
    logic [31:0] mTgt   [64];
    logic        mHitD;
    logic [31:0] mTgtD;

    // last sampled DUT outputs for directed checks
    logic        lastHitF;
    logic [31:0] lastTgtF;
    logic        lastHitD;
    logic [31:0] lastTgtD;

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [32:0] modelLookup(input logic [31:0] pc);
        int idx;
        idx = int'(pc[7:2]);
        if (mValid[idx] && mTag[idx] == pc[31:8]) return {1'b1, mTgt[idx]};
        return {1'b0, 32'h0};
    endfunction

    // One cycle: drive inputs, predict, compare F before the edge and D after it.
    task automatic step(input logic r, input logic [31:0] pf, input logic st, input logic fl,
                        input logic br, input logic tk, input logic [31:0] pm,
                        input logic [31:0] tg);
        logic [32:0] eF;
        logic [32:0] eD;
        logic [32:0] got;
        int idx;
        rst = r; pcF = pf; stallD = st; flushD = fl;
        branchM = br; actual_takeM = tk; pcM = pm; branch_targetM = tg;
        eF = modelLookup(pf);
        exp_q.push_back(eF);
        if (r || fl)  eD = 33'h0;
        else if (!st) eD = eF;
        else          eD = {mHitD, mTgtD};
        expD_q.push_back(eD);
        {mHitD, mTgtD} = eD;
        if (r) begin
            for (int i = 0; i < 64; i++) mValid[i] = 1'b0;
        end else if (br && tk) begin
            idx = int'(pm[7:2]);
            mValid[idx] = 1'b1; mTag[idx] = pm[31:8]; mTgt[idx] = tg;
        end
        @(negedge clk);
        lastHitF = btb_hitF; lastTgtF = btb_targetF;
        if (exp_q.size() == 0) begin
            check("F_queue_empty", 33'h1, 33'h0);
        end else begin
            got = {btb_hitF, btb_targetF};
            check("F_lookup", got, exp_q.pop_front());
        end
        @(posedge clk); #1;
        lastHitD = btb_hitD; lastTgtD = btb_targetD;
        if (expD_q.size() == 0) begin
            check("D_queue_empty", 33'h1, 33'h0);
        end else begin
            got = {btb_hitD, btb_targetD};
            check("D_reg", got, expD_q.pop_front());
        end
    endtask

    task automatic look(input logic [31:0] pf);
        step(1'b0, pf, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic train(input logic [31:0] pf, input logic [31:0] pm, input logic [31:0] tg);
        step(1'b0, pf, 1'b0, 1'b0, 1'b1, 1'b1, pm, tg);
    endtask

    function automatic logic [31:0] randPc();
        return 32'hBFC0_0000 | (32'(($urandom_range(0, 3))) << 8)
                             | (32'(($urandom_range(0, 15))) << 2)
                             | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) begin
            mValid[i] = 1'b0; mTag[i] = '0; mTgt[i] = '0;
        end
        mHitD = 1'b0; mTgtD = 32'h0;
        rst = 1'b1; pcF = 32'h0; stallD = 1'b0; flushD = 1'b0;
        branchM = 1'b0; actual_takeM = 1'b0; pcM = 32'h0; branch_targetM = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hitD", {32'h0, btb_hitD}, 33'h0);
        check("reset_targetD", {1'b0, btb_targetD}, 33'h0);

        // cold lookup
        look(32'hBFC0_0010);
        check("cold_hitF", {32'h0, lastHitF}, 33'h0);
        check("cold_targetF", {1'b0, lastTgtF}, 33'h0);
        check("cold_hitD", {32'h0, lastHitD}, 33'h0);

        // allocate and hit
        train(32'h0, 32'hBFC0_0010, 32'hBFC0_0100);
        look(32'hBFC0_0010);
        check("alloc_hitF", {32'h0, lastHitF}, 33'h1);
        check("alloc_targetF", {1'b0, lastTgtF}, {1'b0, 32'hBFC0_0100});
        check("alloc_D", {lastHitD, lastTgtD}, {1'b1, 32'hBFC0_0100});

        // alias replace; same-cycle lookup sees old contents
        look(32'hBFC0_0110);
        check("alias_miss", {32'h0, lastHitF}, 33'h0);
        train(32'hBFC0_0110, 32'hBFC0_0110, 32'hBFC0_0200);
        check("alias_nobypass", {32'h0, lastHitF}, 33'h0);
        look(32'hBFC0_0110);
        check("alias_new_hit", {lastHitF, lastTgtF}, {1'b1, 32'hBFC0_0200});
        look(32'hBFC0_0010);
        check("alias_old_miss", {32'h0, lastHitF}, 33'h0);

        // not-taken keeps the entry
        step(1'b0, 32'hBFC0_0110, 1'b0, 1'b0, 1'b1, 1'b0, 32'hBFC0_0110, 32'hDEAD_BEEC);
        look(32'hBFC0_0110);
        check("nottaken_keep", {lastHitF, lastTgtF}, {1'b1, 32'hBFC0_0200});

        // bypass: new pc updated and looked up together
        train(32'hBFC0_0020, 32'hBFC0_0020, 32'hBFC0_0303);
        check("bypass_same_cycle", {32'h0, lastHitF}, 33'h0);
        look(32'hBFC0_0020);
        check("bypass_next_cycle", {lastHitF, lastTgtF}, {1'b1, 32'hBFC0_0303});

        // stall holds, flush with stall clears
        train(32'h0, 32'hBFC0_0010, 32'hBFC0_0100);
        look(32'hBFC0_0010);
        check("stall_setup_D", {lastHitD, lastTgtD}, {1'b1, 32'hBFC0_0100});
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'hBFC0_0020, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            check("stall_hold_D", {lastHitD, lastTgtD}, {1'b1, 32'hBFC0_0100});
        end
        step(1'b0, 32'hBFC0_0020, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("flush_over_stall", {lastHitD, lastTgtD}, 33'h0);

        // randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 99) == 0), randPc(),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) != 0),
                 randPc(), $urandom());
        end

        // reset mid-run discards entries and the concurrent update
        train(32'h0, 32'hBFC0_0040, 32'h1000_0000);
        train(32'h0, 32'hBFC0_0044, 32'h1000_0004);
        train(32'h0, 32'hBFC0_0048, 32'h1000_0008);
        train(32'h0, 32'hBFC0_004C, 32'h1000_000C);
        look(32'hBFC0_004C);
        check("populated_hit", {lastHitF, lastTgtF}, {1'b1, 32'h1000_000C});
        step(1'b1, 32'hBFC0_0040, 1'b0, 1'b0, 1'b1, 1'b1, 32'hBFC0_0050, 32'h1000_0010);
        check("rst_clears_D", {lastHitD, lastTgtD}, 33'h0);
        for (int i = 0; i < 5; i++) begin
            look(32'hBFC0_0040 + 32'(i * 4));
            check("rst_all_miss", {32'h0, lastHitF}, 33'h0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer in the fetch stage. It runs alongside the global-history direction predictor.
- Indexed by pcF. Supplies a hit flag and a predicted target to next-PC selection, and pipelines both into decode so they pair with pred_takeD.
- Trained from the M stage with resolved branch outcomes and targets.
- Direction is not stored here; the direction predictor owns it.

Parameters:
- BTB_DEPTH, 6, log2 of entry count (64 entries); index = pc[BTB_DEPTH+1:2].
- TAG_W, 32-2-BTB_DEPTH (24), tag = pc[31:BTB_DEPTH+2], full remaining PC bits, no aliasing on hit.

Ports:
- clk  in  1  clock. All state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- pcF  in  32  fetch PC for lookup.
- stallD  in  1  hold the F->D pipeline register.
- flushD  in  1  clear the F->D pipeline register.
- branchM  in  1  M-stage instruction is a branch/jump with a resolved target.
- actual_takeM  in  1  M-stage branch actually taken.
- pcM  in  32  PC of the M-stage branch.
- branch_targetM  in  32  resolved target of the M-stage branch.
- btb_hitF  out  1  combinational: valid entry with tag match for pcF.
- btb_targetF  out  32  combinational: stored target; 0 when btb_hitF=0.
- btb_hitD  out  1  registered btb_hitF.
- btb_targetD  out  32  registered btb_targetF.

Behaviour:
- Storage: per entry, valid (1), tag (TAG_W), target (32). Target bits [1:0] are stored as written; no realignment.
- Lookup (combinational, F):
  - btb_hitF = valid[idxF] & (tag[idxF] == pcF tag field).
  - btb_targetF = btb_hitF ? target[idxF] : 32'h0.
- Lookup reads array contents as of before the current edge. There is no write-to-read bypass: an update and a lookup to the same entry in the same cycle return the old contents; the new entry is visible the following cycle.
- Update (at the edge, when branchM=1 and actual_takeM=1): write valid=1, tag=pcM tag field, target=branch_targetM at idxM.
  - Unconditional overwrite, whether the entry is a hit, a miss, or an alias with a different tag.
  - If the update is a hit with an identical target, the rewrite is harmless.
- branchM=1 with actual_takeM=0: no change; any existing entry is retained.
- branchM=0: no change.
- F->D register:
  - Priority is rst | flushD over stallD over capture.
  - rst or flushD: btb_hitD=0, btb_targetD=0.
  - Else if ~stallD: capture btb_hitF/btb_targetF.
  - Else: hold.
  - flushD=1 together with stallD=1 clears the register.
- Reset:
  - Clears all valid bits in one cycle. Tag and target arrays need no reset.
  - Outputs after reset: btb_hitD=0, btb_targetD=0; btb_hitF=0 for every pcF until the first update.
  - rst asserted mid-operation discards all entries and any same-cycle update; rst wins over branchM.
- Latency:
  - Lookup: 0 cycles (F).
  - Update: visible to a lookup 1 cycle after the edge.
  - D outputs: 1 cycle after F, subject to stall/flush.
- Simultaneous lookup of idxF and update of a different idxM are fully independent.
- Consumers redirect in D only when pred_takeD & btb_hitD. They also use btb_hitF & the predictor's F-stage take bit for an early fetch redirect.

Decomposition:
- Shared package/header holds:
  - BTB_DEPTH and TAG_W constants.
  - Index/tag field extraction macros or functions, reused by the direction predictor's hash for consistency.
- One sub-module, btb_array, holds:
  - Valid register vector with sync clear.
  - Tag and target arrays.
  - One combinational read port and one synchronous write port.
- The top level adds the tag compare, the target zeroing and the F->D register.

Test Plan:
- Cold lookup: rst 1 cycle, then pcF=0xBFC00010 -> btb_hitF=0, btb_targetF=0; after next edge btb_hitD=0.
- Allocate and hit:
  - Stimulus: branchM=1, actual_takeM=1, pcM=0xBFC00010, branch_targetM=0xBFC00100; next cycle pcF=0xBFC00010.
  - Response: btb_hitF=1, btb_targetF=0xBFC00100; one edge later with stallD=0, btb_hitD=1, btb_targetD=0xBFC00100.
- Alias replace:
  - Stimulus: after the previous case, pcF=0xBFC00110 (same index 4, different tag).
  - Response: btb_hitF=0. Then update pcM=0xBFC00110, target 0xBFC00200 -> 0xBFC00110 hits with 0xBFC00200, and 0xBFC00010 now misses.
- Not-taken and bypass:
  - Not-taken: branchM=1, actual_takeM=0 on an existing entry -> still hits with unchanged target.
  - Bypass: update and lookup of a new pc in the same cycle -> btb_hitF=0 that cycle, 1 the next.
- Stall/flush:
  - Stimulus: hitD=1, target 0xBFC00100 latched, then stallD=1 for 3 cycles with pcF changed.
  - Response: btb_hitD/btb_targetD held. Then stallD=1 with flushD=1 -> both 0 after the edge.
- Reset mid-run: populate 4 entries, then assert rst with branchM=1 in the same cycle -> all lookups miss afterwards, including the pc of the concurrent update.
